o_bufds_tx: RTL and testbench

- Serial transmitter driving a tristateable differential output pair through one O_BUFT_DS primitive.
- Accepts parallel words on a valid/ready handshake and sends a UART-style frame: preamble, start, data LSB-first, optional even parity, stop.
- The pair is tri-stated (Z) when idle and driven only while a frame is in flight.
- Sits at the chip edge as the transmit counterpart of the differential input buffer path, for board-level loopback and IO testcases.

---
 rtl/O_BUFT_DS.sv | 14 +
 rtl/o_bufds_tx.sv | 155 +++++++++++++++
 tb/tb_o_bufds_tx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/O_BUFT_DS.sv
`timescale 1ns/1ps
// Behavioural model of the tristateable differential output buffer primitive.
// The pair floats whenever the enable T is low.
module O_BUFT_DS (
    input  logic I,
    input  logic T,
    output wire  O_P,
    output wire  O_N
);

    assign O_P = T ? I  : 1'bz;
    assign O_N = T ? ~I : 1'bz;

endmodule

// File: rtl/o_bufds_tx.sv
`timescale 1ns/1ps
// UART-style serial transmitter on a tristated differential pair.
// Frame: driven preamble, start, LSB-first data, optional even parity, stop.
module o_bufds_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              line_oe,
    output logic [7:0]        frame_cnt,
    output wire               O_P,
    output wire               O_N
);

    localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              par_bit;
    logic              ser_bit;
    logic              xfer;
    logic              last_cyc;
    logic              pre_last;

    assign xfer      = tx_valid & tx_ready;
    assign shreg_nxt = shreg >> 1;
    assign last_cyc  = (cyc_cnt == CYC_W'(CLKS_PER_BIT - 1));
    assign pre_last  = (CLKS_PER_BIT > 1) && (cyc_cnt == CYC_W'(CLKS_PER_BIT - 2));

    // Single-process FSM; every output is a register so the pad sees no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            ser_bit   <= 1'b0;
            line_oe   <= 1'b0;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (state != S_IDLE) begin
                cyc_cnt <= last_cyc ? '0 : cyc_cnt + CYC_W'(1);
            end
            // Open the accept window one cycle ahead so ready lines up with STOP's last cycle.
            if (state == S_STOP && pre_last) begin
                tx_ready <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        shreg    <= tx_data;
                        par_bit  <= ^tx_data;
                        state    <= S_PRE;
                        ser_bit  <= 1'b1;
                        line_oe  <= 1'b1;
                        tx_busy  <= 1'b1;
                        tx_ready <= 1'b0;
                        cyc_cnt  <= '0;
                    end
                end
                S_PRE: begin
                    if (last_cyc) begin
                        state   <= S_START;
                        ser_bit <= 1'b0;
                    end
                end
                S_START: begin
                    if (last_cyc) begin
                        state   <= S_DATA;
                        ser_bit <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (last_cyc) begin
                        shreg <= shreg_nxt;
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY_EN) begin
                                state   <= S_PARITY;
                                ser_bit <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                ser_bit  <= 1'b1;
                                tx_ready <= (CLKS_PER_BIT == 1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            ser_bit <= shreg_nxt[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (last_cyc) begin
                        state    <= S_STOP;
                        ser_bit  <= 1'b1;
                        tx_ready <= (CLKS_PER_BIT == 1);
                    end
                end
                S_STOP: begin
                    if (last_cyc) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (xfer) begin
                            // Chained word skips the preamble; the line is already settled.
                            shreg    <= tx_data;
                            par_bit  <= ^tx_data;
                            state    <= S_START;
                            ser_bit  <= 1'b0;
                            tx_ready <= 1'b0;
                        end else begin
                            state    <= S_IDLE;
                            ser_bit  <= 1'b0;
                            line_oe  <= 1'b0;
                            tx_busy  <= 1'b0;
                            tx_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    O_BUFT_DS u_obuf (
        .I   (ser_bit),
        .T   (line_oe),
        .O_P (O_P),
        .O_N (O_N)
    );

endmodule

// File: tb/tb_o_bufds_tx.sv
`timescale 1ns/1ps
// Scoreboard bench for o_bufds_tx: default build, parity build and one-cycle-per-bit build.
module tb_o_bufds_tx;

    typedef struct {
        logic b;
        logic last;
    } line_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        bit         chain;
        int         exp_run;
        int         exp_par;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int         sel = 0;
    logic       rst_c = 1'b1;
    logic       tv = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic rst0, rst1, rst2, v0, v1, v2;
    assign rst0 = rst_c | (sel != 0);
    assign rst1 = rst_c | (sel != 1);
    assign rst2 = rst_c | (sel != 2);
    assign v0   = tv & (sel == 0);
    assign v1   = tv & (sel == 1);
    assign v2   = tv & (sel == 2);

    logic       rdy0, rdy1, rdy2, busy0, busy1, busy2, oe0, oe1, oe2;
    logic [7:0] cnt0, cnt1, cnt2;
    wire        p0, p1, p2, n0, n1, n2;

    o_bufds_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst0), .tx_data(tx_data), .tx_valid(v0), .tx_ready(rdy0),
        .tx_busy(busy0), .line_oe(oe0), .frame_cnt(cnt0), .O_P(p0), .O_N(n0));
    o_bufds_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst1), .tx_data(tx_data), .tx_valid(v1), .tx_ready(rdy1),
        .tx_busy(busy1), .line_oe(oe1), .frame_cnt(cnt1), .O_P(p1), .O_N(n1));
    o_bufds_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_dut2 (
        .clk(clk), .rst(rst2), .tx_data(tx_data), .tx_valid(v2), .tx_ready(rdy2),
        .tx_busy(busy2), .line_oe(oe2), .frame_cnt(cnt2), .O_P(p2), .O_N(n2));

    logic       c_rdy, c_busy, c_oe, c_p, c_n;
    logic [7:0] c_cnt;
    always_comb begin
        c_rdy = rdy0; c_busy = busy0; c_oe = oe0; c_p = p0; c_n = n0; c_cnt = cnt0;
        case (sel)
            1: begin c_rdy = rdy1; c_busy = busy1; c_oe = oe1; c_p = p1; c_n = n1; c_cnt = cnt1; end
            2: begin c_rdy = rdy2; c_busy = busy2; c_oe = oe2; c_p = p2; c_n = n2; c_cnt = cnt2; end
            default: ;
        endcase
    end

    line_t      q[$];
    logic [7:0] exp_cnt = 8'd0;
    bit         pend_inc = 1'b0;
    bit         popped = 1'b0;
    int         run = 0;
    int         last_run = 0;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (sel=%0d t=%0t)", nm, act, exp, sel, $time);
        end
    endtask

    // Expected line bits for one frame, one entry per clock.
    function automatic void push_frame(input logic [7:0] d, input bit pre);
        int   cpb;
        logic bits[$];
        line_t e;
        cpb = (sel == 2) ? 1 : 4;
        if (pre) bits.push_back(1'b1);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (sel == 1) bits.push_back(^d);
        bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++) begin
            for (int r = 0; r < cpb; r++) begin
                e.b    = bits[k];
                e.last = (k == bits.size() - 1) && (r == cpb - 1);
                q.push_back(e);
            end
        end
    endfunction

    task automatic tick();
        line_t e;
        logic  nb;
        @(posedge clk);
        @(negedge clk);
        if (pend_inc) exp_cnt = exp_cnt + 8'd1;
        pend_inc = 1'b0;
        if (q.size() != 0) begin
            e = q.pop_front();
            nb = ~e.b;
            popped = 1'b1;
            chk("line_oe", c_oe, 1);
            chk("O_P", c_p, e.b);
            chk("O_N", c_n, nb);
            chk("tx_busy", c_busy, 1);
            pend_inc = e.last;
        end else begin
            popped = 1'b0;
            chk("line_oe_idle", c_oe, 0);
            chk("tx_busy_idle", c_busy, 0);
        end
        chk("tx_ready", c_rdy, q.size() == 0);
        chk("frame_cnt", c_cnt, exp_cnt);
        if (c_oe === 1'b1) begin
            run++;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_cnt  = 8'd0;
        pend_inc = 1'b0;
        popped   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_c = 1'b1;
        model_reset();
        repeat (n) tick();
        rst_c = 1'b0;
    endtask

    // Hold the word valid until the model says the DUT is ready, then account for the transfer.
    task automatic send(input logic [7:0] d);
        tv = 1'b1;
        tx_data = d;
        while (q.size() != 0) tick();
        push_frame(d, !popped);
        tick();
        tv = 1'b0;
    endtask

    task automatic wait_idle();
        tv = 1'b0;
        while (q.size() != 0) tick();
        tick();
        tick();
    endtask

    vec_t vecs[5];

    task automatic run_vec(input int i);
        if (vecs[i].sel != sel) begin
            sel = vecs[i].sel;
            do_reset(3);
        end
        send(vecs[i].data);
        if (vecs[i].exp_par >= 0) begin
            repeat (40) tick();
            chk("parity_bit", c_p, vecs[i].exp_par);
        end
        if (!vecs[i].chain) begin
            wait_idle();
            chk("frame_len", last_run, vecs[i].exp_run);
        end
    endtask

    initial begin
        vecs[0] = '{sel: 0, data: 8'hA5, chain: 1'b0, exp_run: 44, exp_par: -1};
        vecs[1] = '{sel: 0, data: 8'h01, chain: 1'b1, exp_run: 0,  exp_par: -1};
        vecs[2] = '{sel: 0, data: 8'h80, chain: 1'b0, exp_run: 84, exp_par: -1};
        vecs[3] = '{sel: 1, data: 8'h07, chain: 1'b0, exp_run: 48, exp_par: 1};
        vecs[4] = '{sel: 1, data: 8'h03, chain: 1'b0, exp_run: 48, exp_par: 0};

        sel = 0;
        do_reset(3);
        repeat (20) tick();

        for (int i = 0; i < 3; i++) run_vec(i);
        chk("frame_cnt_after_three", c_cnt, 3);

        // Reset and valid together: reset wins and nothing is sent.
        rst_c = 1'b1;
        tv = 1'b1;
        tx_data = 8'hAA;
        model_reset();
        tick();
        rst_c = 1'b0;
        tv = 1'b0;
        repeat (4) tick();

        // Reset in DATA bit 3 drops the frame immediately.
        send(8'h5A);
        repeat (21) tick();
        chk("mid_frame_oe_before_rst", c_oe, 1);
        rst_c = 1'b1;
        model_reset();
        tick();
        rst_c = 1'b0;
        chk("rst_line_oe", c_oe, 0);
        chk("rst_busy", c_busy, 0);
        chk("rst_cnt", c_cnt, 0);
        repeat (3) tick();
        send(8'h3C);
        wait_idle();
        chk("post_rst_len", last_run, 44);
        chk("post_rst_cnt", c_cnt, 1);

        for (int i = 3; i < 5; i++) run_vec(i);

        // Counter wrap with one clock per bit.
        sel = 2;
        do_reset(3);
        for (int k = 0; k < 256; k++) begin
            send(8'hFF);
            wait_idle();
            chk("len_cpb1", last_run, 11);
            if (k == 254) chk("cnt_255", c_cnt, 255);
        end
        chk("cnt_wrap", c_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
